uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Generic single-clock FIFO; read data is the head word, visible while rd_vld is high.
// Latency: a write is visible at the head one edge later. Backpressure: wr_rdy low while full.
// A same-edge pop does not free a slot for the write.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_vld,
    output logic                   wr_rdy,
    input  logic [WIDTH-1:0]       wr_dat,
    output logic                   rd_vld,
    input  logic                   rd_rdy,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push, pop;

    assign wr_rdy = (count_q != (PTR_W + 1)'(DEPTH));
    assign rd_vld = (count_q != '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_rdy && rd_vld;
    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end
endmodule

// Queued UART transmitter with configurable width, divisor, parity and stop bits.
// Latency: a word written to an idle, empty block drives the start bit two edges later.
// Backpressure: tx_ready drops while the FIFO is full; queued frames go out back-to-back.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 5208,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        TX,
    output logic                        tx_done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int BAUD_W   = $clog2(BAUD_DIV);
    localparam int MAX_BITS = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BIT_W    = $clog2(MAX_BITS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    if (DATA_BITS < 5 || DATA_BITS > 9 || BAUD_DIV < 2 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_fifo: illegal parameter value");
    end

    logic [2:0]           state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 strobe, pop, fifo_vld;
    logic [DATA_BITS-1:0] fifo_dat;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (tx_valid),
        .wr_rdy (tx_ready),
        .wr_dat (tx_data),
        .rd_vld (fifo_vld),
        .rd_rdy (pop),
        .rd_dat (fifo_dat),
        .count  (fifo_count)
    );

    assign strobe = (baud_q == BAUD_W'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (state_q != S_IDLE) baud_d = strobe ? '0 : baud_q + 1'b1;
        case (state_q)
            S_IDLE:  pop = fifo_vld;
            S_START: if (strobe) state_d = S_DATA;
            S_DATA: if (strobe) begin
                shift_d = shift_q >> 1;
                if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = (PARITY != 0) ? S_PAR : S_STOP;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            S_PAR:   if (strobe) state_d = S_STOP;
            S_STOP: if (strobe) begin
                if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                    done_d  = 1'b1;
                    bit_d   = '0;
                    state_d = S_IDLE;
                    pop     = fifo_vld;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Parity comes from the whole popped word, before any shifting.
        if (pop) begin
            shift_d = fifo_dat;
            par_d   = (^fifo_dat) ^ (PARITY == 2);
            baud_d  = '0;
            bit_d   = '0;
            state_d = S_START;
        end
    end

    always_comb begin
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            S_PAR:   tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign TX      = tx_q;
    assign tx_done = done_q;
    assign busy    = (state_q != S_IDLE) || fifo_vld;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations share one clock; expected line waveforms are
// built from the frame format rules and compared cycle by cycle.
module tb_uart_tx_fifo;
    localparam int NI   = 4;
    localparam int BAUD = 16;
    localparam int DB [NI] = '{8, 8, 8, 7};
    localparam int PB [NI] = '{0, 1, 2, 0};
    localparam int SB [NI] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst        [NI];
    logic       tx_valid   [NI];
    logic [8:0] tx_data    [NI];
    logic       tx_ready   [NI];
    logic       tx_line    [NI];
    logic       tx_done    [NI];
    logic       busy       [NI];
    logic [2:0] fifo_count [NI];
    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_fifo #(
            .DATA_BITS(DB[g]), .BAUD_DIV(BAUD), .PARITY(PB[g]),
            .STOP_BITS(SB[g]), .FIFO_DEPTH(4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .tx_data    (tx_data[g][DB[g]-1:0]),
            .tx_valid   (tx_valid[g]),
            .tx_ready   (tx_ready[g]),
            .TX         (tx_line[g]),
            .tx_done    (tx_done[g]),
            .busy       (busy[g]),
            .fifo_count (fifo_count[g])
        );
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Drive one write for one edge; caller sits at a falling edge.
    task automatic push(input int k, input logic [8:0] w);
        tx_valid[k] = 1'b1;
        tx_data[k]  = w;
        @(negedge clk);
        tx_valid[k] = 1'b0;
        tx_data[k]  = 9'($urandom);
    endtask

    task automatic wait_fall(input int k, output bit ok);
        int t;
        t = 0;
        while (tx_line[k] !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        ok = (tx_line[k] === 1'b0);
        if (!ok) begin
            nvec++;
            nbad++;
            $display("FAIL start_timeout[%0d]: TX stayed %b, required 0 within 2000 cycles", k, tx_line[k]);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1s, each BAUD cycles;
    // tx_done high only in the very last cycle. Entry point is the first cycle of the frame.
    task automatic check_frame(input int k, input logic [8:0] w, input string name);
        logic       bits [$];
        logic [8:0] d;
        logic       p, seen, dseen;
        bit         bad, dbad;
        d = w & 9'((1 << DB[k]) - 1);
        bits.push_back(1'b0);
        for (int i = 0; i < DB[k]; i++) bits.push_back(d[i]);
        if (PB[k] != 0) begin
            p = ($countones(d) % 2 == 1);
            if (PB[k] == 2) p = ~p;
            bits.push_back(p);
        end
        for (int i = 0; i < SB[k]; i++) bits.push_back(1'b1);
        dbad  = 1'b0;
        dseen = 1'b0;
        foreach (bits[b]) begin
            bad  = 1'b0;
            seen = bits[b];
            for (int c = 0; c < BAUD; c++) begin
                if (tx_line[k] !== bits[b]) begin
                    bad  = 1'b1;
                    seen = tx_line[k];
                end
                if (tx_done[k] !== 1'((b == bits.size() - 1) && (c == BAUD - 1))) begin
                    dbad  = 1'b1;
                    dseen = tx_done[k];
                end
                @(negedge clk);
            end
            nvec++;
            if (bad) begin
                nbad++;
                $display("FAIL %s bit%0d (word %h): TX saw %b, required %b for %0d cycles",
                         name, b, d, seen, bits[b], BAUD);
            end
        end
        nvec++;
        if (dbad) begin
            nbad++;
            $display("FAIL %s tx_done (word %h): saw %b in a cycle other than the last stop cycle",
                     name, d, dseen);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) rst[k] = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            nvec++;
            if ({tx_line[k], tx_done[k], busy[k], tx_ready[k], fifo_count[k]} !== 7'b1001000) begin
                nbad++;
                $display("FAIL reset[%0d]: {TX,done,busy,ready,count}=%b, required 1001000", k,
                         {tx_line[k], tx_done[k], busy[k], tx_ready[k], fifo_count[k]});
            end
            rst[k] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        push(0, 9'h0A5);
        nvec++;
        if ({tx_line[0], busy[0], fifo_count[0]} !== 5'b11001) begin
            nbad++;
            $display("FAIL latency_write: {TX,busy,count}=%b, required 11001", {tx_line[0], busy[0], fifo_count[0]});
        end
        @(negedge clk);
        nvec++;
        if ({tx_line[0], fifo_count[0]} !== 4'b1000) begin
            nbad++;
            $display("FAIL latency_pop: {TX,count}=%b, required 1000", {tx_line[0], fifo_count[0]});
        end
        @(negedge clk);
        nvec++;
        if (tx_line[0] !== 1'b0) begin
            nbad++;
            $display("FAIL latency_start: TX=%b, required 0 two edges after the write", tx_line[0]);
        end
        check_frame(0, 9'h0A5, "basic_a5");
        nvec++;
        if ({tx_line[0], busy[0]} !== 2'b10) begin
            nbad++;
            $display("FAIL basic_idle: {TX,busy}=%b, required 10", {tx_line[0], busy[0]});
        end
    endtask

    task automatic test_parity();
        bit ok;
        push(1, 9'h007);
        wait_fall(1, ok);
        if (ok) check_frame(1, 9'h007, "even_07");
        push(2, 9'h007);
        wait_fall(2, ok);
        if (ok) check_frame(2, 9'h007, "odd_07");
        push(1, 9'h000);
        wait_fall(1, ok);
        if (ok) check_frame(1, 9'h000, "even_00");
        nvec++;
        if ({tx_line[1], busy[1], tx_line[2], busy[2]} !== 4'b1010) begin
            nbad++;
            $display("FAIL parity_idle: {TX1,busy1,TX2,busy2}=%b, required 1010",
                     {tx_line[1], busy[1], tx_line[2], busy[2]});
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        tx_valid[3] = 1'b1;
        tx_data[3]  = 9'h055;
        @(negedge clk);
        tx_data[3]  = 9'h02A;
        @(negedge clk);
        tx_valid[3] = 1'b0;
        wait_fall(3, ok);
        if (ok) begin
            check_frame(3, 9'h055, "b2b_first");
            check_frame(3, 9'h02A, "b2b_second");
        end
        nvec++;
        if ({tx_line[3], busy[3], tx_done[3]} !== 3'b100) begin
            nbad++;
            $display("FAIL b2b_idle: {TX,busy,done}=%b, required 100", {tx_line[3], busy[3], tx_done[3]});
        end
    endtask

    task automatic test_fifo_fill();
        int  cnt, t;
        bit  exp_rdy, ok;
        logic prev;
        fork
            begin
                cnt = 0;
                for (int i = 1; i <= 8; i++) begin
                    tx_valid[0] = 1'b1;
                    tx_data[0]  = 9'(i);
                    exp_rdy = (cnt < 4);
                    nvec++;
                    if (tx_ready[0] !== exp_rdy) begin
                        nbad++;
                        $display("FAIL fill_ready word%0d: tx_ready=%b, required %b", i, tx_ready[0], exp_rdy);
                    end
                    if (exp_rdy) cnt++;
                    // Word 1 moves to the shift register on the edge that takes word 2.
                    if (i == 2) cnt--;
                    @(negedge clk);
                end
                tx_valid[0] = 1'b0;
                nvec++;
                if (fifo_count[0] !== 3'(cnt)) begin
                    nbad++;
                    $display("FAIL fill_count: fifo_count=%0d, required %0d", fifo_count[0], cnt);
                end
            end
            begin
                wait_fall(0, ok);
                if (ok) for (int w = 1; w <= 5; w++) check_frame(0, 9'(w), "fill_order");
            end
            begin
                prev = tx_ready[0];
                t = 0;
                while (tx_done[0] !== 1'b1 && t < 600) begin
                    prev = tx_ready[0];
                    @(negedge clk);
                    t++;
                end
                nvec++;
                if (!(prev === 1'b0 && tx_ready[0] === 1'b1)) begin
                    nbad++;
                    $display("FAIL fill_ready_return: tx_ready before/at pop of word 2 = %b/%b, required 0/1",
                             prev, tx_ready[0]);
                end
            end
        join
        nvec++;
        if ({tx_line[0], busy[0], fifo_count[0]} !== 5'b10000) begin
            nbad++;
            $display("FAIL fill_idle: {TX,busy,count}=%b, required 10000", {tx_line[0], busy[0], fifo_count[0]});
        end
    endtask

    task automatic test_same_edge();
        logic [8:0] w [4];
        for (int i = 0; i < 4; i++) w[i] = 9'($urandom);
        for (int i = 0; i < 3; i++) push(0, w[i]);
        fork
            begin
                for (int i = 0; i < 4; i++) check_frame(0, w[i], "pushpop_order");
            end
            begin
                repeat (BAUD * 10 - 2) @(negedge clk);
                nvec++;
                if (fifo_count[0] !== 3'd2) begin
                    nbad++;
                    $display("FAIL pushpop_before: fifo_count=%0d, required 2", fifo_count[0]);
                end
                tx_valid[0] = 1'b1;
                tx_data[0]  = w[3];
                @(negedge clk);
                tx_valid[0] = 1'b0;
                nvec++;
                if ({tx_done[0], fifo_count[0]} !== 4'b1010) begin
                    nbad++;
                    $display("FAIL pushpop_count: {done,count}=%b, required 1010", {tx_done[0], fifo_count[0]});
                end
            end
        join
    endtask

    task automatic test_reset_mid();
        bit ok, stray;
        logic [8:0] w;
        for (int i = 0; i < 3; i++) push(0, 9'($urandom));
        repeat (3 * BAUD + 5) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        nvec++;
        if ({tx_line[0], busy[0], tx_done[0], tx_ready[0], fifo_count[0]} !== 7'b1001000) begin
            nbad++;
            $display("FAIL reset_mid: {TX,busy,done,ready,count}=%b, required 1001000",
                     {tx_line[0], busy[0], tx_done[0], tx_ready[0], fifo_count[0]});
        end
        rst[0] = 1'b0;
        stray = 1'b0;
        repeat (3 * BAUD) begin
            @(negedge clk);
            if (tx_line[0] !== 1'b1 || busy[0] !== 1'b0) stray = 1'b1;
        end
        nvec++;
        if (stray) begin
            nbad++;
            $display("FAIL reset_discard: line or busy active after reset, required TX=1 busy=0");
        end
        w = 9'($urandom);
        push(0, w);
        wait_fall(0, ok);
        if (ok) check_frame(0, w, "after_reset");
    endtask

    task automatic test_random(input int k, input int n);
        logic [8:0] q [$];
        int gap, t;
        bit ok;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    gap = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 400) : $urandom_range(0, 3);
                    repeat (gap) begin
                        tx_data[k] = 9'($urandom);
                        @(negedge clk);
                    end
                    tx_valid[k] = 1'b1;
                    tx_data[k]  = 9'($urandom);
                    t = 0;
                    while (tx_ready[k] !== 1'b1 && t < 3000) begin
                        @(negedge clk);
                        tx_data[k] = 9'($urandom);
                        t++;
                    end
                    if (tx_ready[k] !== 1'b1) begin
                        nvec++;
                        nbad++;
                        $display("FAIL random_write[%0d]: tx_ready=%b, required 1 within 3000 cycles", k, tx_ready[k]);
                        tx_valid[k] = 1'b0;
                        break;
                    end
                    q.push_back(tx_data[k]);
                    @(negedge clk);
                    tx_valid[k] = 1'b0;
                end
            end
            begin
                for (int i = 0; i < n; i++) begin
                    wait_fall(k, ok);
                    if (!ok) break;
                    if (q.size() == 0) begin
                        nvec++;
                        nbad++;
                        $display("FAIL random_extra[%0d]: frame started with 0 words written, required none", k);
                        break;
                    end
                    check_frame(k, q.pop_front(), "random");
                end
            end
        join
        nvec++;
        if ({tx_line[k], busy[k], fifo_count[k]} !== 5'b10000) begin
            nbad++;
            $display("FAIL random_idle[%0d]: {TX,busy,count}=%b, required 10000", k,
                     {tx_line[k], busy[k], fifo_count[k]});
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k]      = 1'b1;
            tx_valid[k] = 1'b0;
            tx_data[k]  = '0;
        end
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_fifo_fill();
        test_same_edge();
        test_reset_mid();
        test_random(0, 12);
        test_random(2, 8);
        test_random(3, 8);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
